label_bitmap_packer: RTL
========================

// Module: label_bitmap_packer
// PURPOSE
//  Reverse path of the connected-component labeler: reads the 32x32 label map from label SRAM
//  (one 8-bit label per pixel, row-major, 0 = background) and repacks it into a 128-byte binary
//  bitmap in input-ROM layout (8 pixels/byte, MSB = leftmost pixel). Optional label select
//  extracts a single component mask; also counts set pixels. Sits after the labeler, feeds bitmap RAM.
// PARAMETERS
//  IMG_W   32  image width in pixels; multiple of 8
//  IMG_H   32  image height in pixels
//  LBL_W    8  label width in bits
// PORTS
//  clk        in   1   clock, all logic on rising edge
//  reset      in   1   synchronous, active-low reset
//  start      in   1   one-cycle request; sampled only in IDLE
//  sel_label  in   8   0: bit = (label != 0); else bit = (label == sel_label); latched at start
//  sram_a     out  10  label SRAM read address (pixel index row*IMG_W+col)
//  sram_q     in   8   label SRAM read data, valid the cycle after sram_a
//  bmp_a      out  7   bitmap write address, byte k = pixels 8k..8k+7
//  bmp_d      out  8   bitmap write data; bit7 = pixel 8k, bit0 = pixel 8k+7
//  bmp_wen    out  1   bitmap write enable, active low, one cycle per byte
//  busy       out  1   high from first read cycle until last write done
//  finish     out  1   high after completion; held until next accepted start
//  pix_count  out  11  number of 1 bits written (0..1024); valid when finish=1
// BEHAVIOUR
//  - Reset (reset=0 at an edge): state IDLE; sram_a=0, bmp_a=0, bmp_d=0, bmp_wen=1, busy=0,
//    finish=0, pix_count=0, shift reg/counters cleared. Reset mid-run aborts with no further writes.
//  - States: IDLE -> (start=1) READ -> DRAIN -> DONE -> (start=1) READ. start ignored in READ/DRAIN.
//  - Cycle 0 = first cycle after start accepted: busy=1, sram_a=0, finish=0, pix_count=0.
//  - READ: sram_a presents n in cycle n, n = 0..1023; after cycle 1023 -> DRAIN (sram_a holds 1023).
//  - Pixel n is taken from sram_q in cycle n+1, mask rule applied, shifted into byte LSB-side.
//  - Byte k (after pixel 8k+7) is registered out: bmp_wen=0, bmp_a=k, bmp_d=byte in cycle 8k+9.
//    k=0 in cycle 9, k=127 in cycle 1025; bmp_wen=1 all other cycles; bmp_a/bmp_d hold between.
//  - pix_count += popcount of each byte as written; 11-bit, no wrap (max 1024).
//  - DRAIN ends after the k=127 write; DONE from cycle 1026: busy=0, finish=1, bmp_wen=1.
//  - Start in DONE clears finish and pix_count and restarts at cycle 0 next cycle; sel_label re-latched.
//  - Label 8'hFF is an ordinary nonzero label (matches sel_label=8'hFF, counts as set when sel=0).
//  - Exactly 128 writes per run; no write to any address twice; no reads after address 1023.
// TESTING
//  1. All labels 0, sel=0 -> 128 writes of 8'h00 at bmp_a 0..127, pix_count=0, finish cycle 1026.
//  2. All labels 8'h03, sel=0 -> all bytes 8'hFF, pix_count=1024; sel=8'h05 -> all 8'h00, count 0.
//  3. Label n = (n%2)?1:2, sel=1 -> every byte 8'h55, pix_count=512; sel=2 -> 8'hAA, count 512.
//  4. Only pixel 0 label 7, pixel 1023 label 8'hFF, sel=0 -> byte0=8'h80, byte127=8'h01, count 2.
//  5. Timing: first bmp_wen=0 in cycle 9, last in 1025, busy 0..1025; start pulsed in cycle 500
//     ignored (no restart, results unchanged).
//  6. Reset asserted at cycle 300 -> next cycle all outputs at reset values, no further writes;
//     new start afterwards runs full 128-byte sequence correctly.

Source files
------------

// File: rtl/label_bitmap_packer.sv
// Repacks the 8-bit label map into a 1-bit-per-pixel bitmap, MSB = leftmost pixel,
// optionally isolating a single label, and counts the pixels it sets.
module label_bitmap_packer #(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32,
    parameter int LBL_W = 8,
    localparam int NPIX = IMG_W * IMG_H,
    localparam int AW = $clog2(NPIX),
    localparam int BW = $clog2(NPIX / 8),
    localparam int CW = $clog2(NPIX + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LBL_W-1:0] sel_label,
    output logic [AW-1:0]    sram_a,
    input  logic [LBL_W-1:0] sram_q,
    output logic [BW-1:0]    bmp_a,
    output logic [7:0]       bmp_d,
    output logic             bmp_wen,
    output logic             busy,
    output logic             finish,
    output logic [CW-1:0]    pix_count
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    localparam logic [AW-1:0] LAST_A = AW'(NPIX - 1);
    localparam logic [BW-1:0] LAST_B = BW'(NPIX / 8 - 1);

    state_t           state;
    state_t           state_nxt;
    logic [LBL_W-1:0] sel_q;
    logic             rd_vld;
    logic [2:0]       px;
    logic [BW-1:0]    bcnt;
    logic [6:0]       shreg;
    logic             pix_bit;
    logic [7:0]       nxt_byte;
    logic             accept;

    function automatic logic [3:0] ones(input logic [7:0] b);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, b[i]};
        return n;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (start) state_nxt = READ;
            READ:  if (sram_a == LAST_A) state_nxt = DRAIN;
            DRAIN: if (!bmp_wen && bmp_a == LAST_B) state_nxt = DONE;
            DONE:  if (start) state_nxt = READ;
        endcase
    end

    always_comb begin
        busy   = (state == READ) || (state == DRAIN);
        finish = (state == DONE);
        accept = start && ((state == IDLE) || (state == DONE));
    end

    // sel_q == 0 means "any foreground label"
    assign pix_bit  = (sel_q == '0) ? (sram_q != '0) : (sram_q == sel_q);
    assign nxt_byte = {shreg, pix_bit};

    always_ff @(posedge clk) begin
        if (!reset) begin
            sram_a    <= '0;
            bmp_a     <= '0;
            bmp_d     <= '0;
            bmp_wen   <= 1'b1;
            pix_count <= '0;
            sel_q     <= '0;
            rd_vld    <= 1'b0;
            px        <= '0;
            bcnt      <= '0;
            shreg     <= '0;
        end else begin
            bmp_wen <= 1'b1;
            rd_vld  <= (state == READ);
            if (accept) begin
                sram_a    <= '0;
                sel_q     <= sel_label;
                pix_count <= '0;
                px        <= '0;
                bcnt      <= '0;
                shreg     <= '0;
            end else begin
                if (state == READ && sram_a != LAST_A)
                    sram_a <= sram_a + AW'(1);
                // rd_vld marks that sram_q carries last cycle's read
                if (rd_vld) begin
                    shreg <= nxt_byte[6:0];
                    px    <= px + 3'd1;
                    if (px == 3'd7) begin
                        bmp_wen   <= 1'b0;
                        bmp_a     <= bcnt;
                        bmp_d     <= nxt_byte;
                        bcnt      <= bcnt + BW'(1);
                        pix_count <= pix_count + CW'(ones(nxt_byte));
                    end
                end
            end
        end
    end

endmodule
